// File: rtl/multiplier_pkg.sv
// Shared types and width helpers for the sequential shift-and-add multiplier.
package multiplier_pkg;

   typedef enum logic {
      StIdle = 1'b0,
      StBusy = 1'b1
   } state_e;

   localparam int unsigned DefaultDataWidth = 16;

   function automatic int unsigned prod_width(input int unsigned data_width);
      return 2 * data_width;
   endfunction

   // Enough bits to hold the iteration count DATA_WIDTH itself.
   function automatic int unsigned cnt_width(input int unsigned data_width);
      return $clog2(data_width + 1);
   endfunction

endpackage

// File: rtl/multiplier_if.sv
// Start/Ready operand and result bundle for the multiplier.
interface multiplier_if #(
   parameter int unsigned DATA_WIDTH = 16
);

   logic [DATA_WIDTH-1:0]   InputA;
   logic [DATA_WIDTH-1:0]   InputB;
   logic                    Start;
   logic [2*DATA_WIDTH-1:0] Product;
   logic                    Ready;

   modport master (
      output InputA,
      output InputB,
      output Start,
      input  Product,
      input  Ready
   );

   modport slave (
      input  InputA,
      input  InputB,
      input  Start,
      output Product,
      output Ready
   );

endinterface

// File: rtl/multiplier_step.sv
// One shift-and-add iteration: conditional accumulate, then shift both operands.
module multiplier_step #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned PROD_WIDTH = 32
) (
   input  logic [PROD_WIDTH-1:0] i_acc,
   input  logic [PROD_WIDTH-1:0] i_mcand,
   input  logic [DATA_WIDTH-1:0] i_mplier,
   output logic [PROD_WIDTH-1:0] o_acc,
   output logic [PROD_WIDTH-1:0] o_mcand,
   output logic [DATA_WIDTH-1:0] o_mplier
);

   assign o_acc    = i_mplier[0] ? (i_acc + i_mcand) : i_acc;
   assign o_mcand  = i_mcand << 1;
   assign o_mplier = i_mplier >> 1;

endmodule

// File: rtl/multiplier.sv
// Sequential unsigned multiplier: one partial product per cycle, DATA_WIDTH cycles per result.
module multiplier
   import multiplier_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DefaultDataWidth
) (
   input logic          Clk,
   input logic          Reset,
   multiplier_if.slave  mul_bus
);

   localparam int unsigned PROD_WIDTH = prod_width(DATA_WIDTH);
   localparam int unsigned CNT_WIDTH  = cnt_width(DATA_WIDTH);

   state_e                r_state;
   logic                  r_start_q;
   logic                  r_ready;
   logic [PROD_WIDTH-1:0] r_product;
   logic [PROD_WIDTH-1:0] r_acc;
   logic [PROD_WIDTH-1:0] r_mcand;
   logic [DATA_WIDTH-1:0] r_mplier;
   logic [CNT_WIDTH-1:0]  r_cnt;

   logic [PROD_WIDTH-1:0] w_acc;
   logic [PROD_WIDTH-1:0] w_mcand;
   logic [DATA_WIDTH-1:0] w_mplier;
   logic                  w_launch;

   multiplier_step #(
      .DATA_WIDTH (DATA_WIDTH),
      .PROD_WIDTH (PROD_WIDTH)
   ) u_step (
      .i_acc    (r_acc),
      .i_mcand  (r_mcand),
      .i_mplier (r_mplier),
      .o_acc    (w_acc),
      .o_mcand  (w_mcand),
      .o_mplier (w_mplier)
   );

   // Edge-triggered launch: a Start held high across completion must not relaunch.
   assign w_launch = mul_bus.Start && !r_start_q;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state   <= StIdle;
         r_start_q <= 1'b0;
         r_ready   <= 1'b1;
         r_product <= '0;
         r_acc     <= '0;
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_cnt     <= '0;
      end else begin
         r_start_q <= mul_bus.Start;
         unique case (r_state)
            StIdle: begin
               if (w_launch) begin
                  r_mcand  <= {{DATA_WIDTH{1'b0}}, mul_bus.InputA};
                  r_mplier <= mul_bus.InputB;
                  r_acc    <= '0;
                  r_cnt    <= CNT_WIDTH'(DATA_WIDTH);
                  r_ready  <= 1'b0;
                  r_state  <= StBusy;
               end
            end
            StBusy: begin
               r_acc    <= w_acc;
               r_mcand  <= w_mcand;
               r_mplier <= w_mplier;
               r_cnt    <= r_cnt - CNT_WIDTH'(1);
               if (r_cnt == CNT_WIDTH'(1)) begin
                  r_product <= w_acc;
                  r_ready   <= 1'b1;
                  r_state   <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign mul_bus.Product = r_product;
   assign mul_bus.Ready   = r_ready;

endmodule

// File: tb/tb_multiplier.sv
// Directed-vector bench for the sequential multiplier at DATA_WIDTH=16.
module tb_multiplier;

   localparam int unsigned DW = 16;

   typedef struct {
      logic [DW-1:0]   a;
      logic [DW-1:0]   b;
      logic [2*DW-1:0] p;
   } vec_t;

   logic Clk;
   logic Reset;
   int   n_tests;
   int   n_fail;
   vec_t vecs[9];

   multiplier_if #(.DATA_WIDTH(DW)) mul_bus ();

   multiplier #(.DATA_WIDTH(DW)) dut (
      .Clk     (Clk),
      .Reset   (Reset),
      .mul_bus (mul_bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive operands with Start high; returns at the negedge after the launch edge.
   task automatic launch(input string name, input logic [DW-1:0] a, input logic [DW-1:0] b);
      mul_bus.InputA = a;
      mul_bus.InputB = b;
      mul_bus.Start  = 1'b1;
      @(negedge Clk);
      check({name, "_launch"}, 64'(mul_bus.Ready), 64'd0);
   endtask

   // Counts the Ready-low window and checks Product is held until completion.
   task automatic finish_op(input string name, input logic [2*DW-1:0] exp,
                            input bit drop_start, input bit disturb);
      logic [2*DW-1:0] prev;
      int              cnt;
      bit              held;
      prev = mul_bus.Product;
      cnt  = 0;
      held = 1'b1;
      if (drop_start) mul_bus.Start = 1'b0;
      while (mul_bus.Ready == 1'b0 && cnt < 40) begin
         cnt++;
         if (mul_bus.Product !== prev) held = 1'b0;
         if (disturb && cnt == 5) begin
            mul_bus.InputA = 16'hFFFF;
            mul_bus.InputB = 16'hFFFF;
            mul_bus.Start  = 1'b1;
         end
         if (disturb && cnt == 6) mul_bus.Start = 1'b0;
         @(negedge Clk);
      end
      check({name, "_cycles"}, 64'(cnt), 64'd16);
      check({name, "_product"}, 64'(mul_bus.Product), 64'(exp));
      check({name, "_held"}, 64'(held), 64'd1);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      vecs[0] = '{a: 16'd4,      b: 16'd5,      p: 32'd20};
      vecs[1] = '{a: 16'hFFFF,   b: 16'hFFFF,   p: 32'hFFFE0001};
      vecs[2] = '{a: 16'd0,      b: 16'h1234,   p: 32'd0};
      vecs[3] = '{a: 16'd2,      b: 16'd3,      p: 32'd6};
      vecs[4] = '{a: 16'd100,    b: 16'd200,    p: 32'd20000};
      vecs[5] = '{a: 16'd1,      b: 16'hFFFF,   p: 32'h0000FFFF};
      vecs[6] = '{a: 16'hFFFF,   b: 16'd1,      p: 32'h0000FFFF};
      vecs[7] = '{a: 16'h8000,   b: 16'd2,      p: 32'h00010000};
      vecs[8] = '{a: 16'h1234,   b: 16'h5678,   p: 32'h06260060};

      Reset          = 1'b1;
      mul_bus.Start  = 1'b0;
      mul_bus.InputA = '0;
      mul_bus.InputB = '0;
      repeat (2) @(negedge Clk);
      check("rst_ready", 64'(mul_bus.Ready), 64'd1);
      check("rst_product", 64'(mul_bus.Product), 64'd0);
      Reset = 1'b0;
      @(negedge Clk);
      check("idle_ready", 64'(mul_bus.Ready), 64'd1);

      // Back-to-back table operations, Start dropped after the launch edge.
      for (int i = 0; i < 9; i++) begin
         launch($sformatf("vec%0d", i), vecs[i].a, vecs[i].b);
         finish_op($sformatf("vec%0d", i), vecs[i].p, 1'b1, 1'b0);
      end

      // Start held through completion: exactly one operation.
      launch("hold", 16'd3, 16'd7);
      finish_op("hold", 32'd21, 1'b0, 1'b0);
      begin
         bit stayed;
         stayed = 1'b1;
         repeat (5) begin
            @(negedge Clk);
            if (mul_bus.Ready !== 1'b1) stayed = 1'b0;
         end
         check("hold_no_relaunch", 64'(stayed), 64'd1);
      end
      mul_bus.Start = 1'b0;
      @(negedge Clk);
      launch("relaunch", 16'd2, 16'd2);
      finish_op("relaunch", 32'd4, 1'b1, 1'b0);

      // Operand change and Start pulse mid-operation are ignored.
      launch("disturb", 16'd10, 16'd11);
      finish_op("disturb", 32'd110, 1'b1, 1'b1);
      @(negedge Clk);
      check("disturb_idle", 64'(mul_bus.Ready), 64'd1);

      // Reset during the fifth busy cycle aborts.
      launch("abort", 16'd7, 16'd7);
      mul_bus.Start = 1'b0;
      repeat (4) @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      check("abort_ready", 64'(mul_bus.Ready), 64'd1);
      check("abort_product", 64'(mul_bus.Product), 64'd0);
      Reset = 1'b0;
      @(negedge Clk);
      launch("after_abort", 16'd6, 16'd9);
      finish_op("after_abort", 32'd54, 1'b1, 1'b0);

      // Start already high when reset releases launches immediately.
      Reset          = 1'b1;
      mul_bus.InputA = 16'd5;
      mul_bus.InputB = 16'd5;
      mul_bus.Start  = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      check("rst_start_launch", 64'(mul_bus.Ready), 64'd0);
      finish_op("rst_start", 32'd25, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
